// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding / load-use hazard controller:
// operand-mux select codes, FSM states and shadow-stage metadata.
package fwd_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] SEL_REGF = 2'b00;
  localparam logic [SEL_W-1:0] SEL_WB   = 2'b01;
  localparam logic [SEL_W-1:0] SEL_MEM  = 2'b10;

  typedef enum logic [0:0] {
    StRun,
    StLuStall
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
    logic             regwrite;
    logic             memread;
  } stage_t;

endpackage

// File: rtl/fwd_match.sv
// Combinational comparator: does a shadow stage produce the register an ID operand reads?
module fwd_match
  import fwd_pkg::*;
(
  input  stage_t           stage,
  input  logic [REG_W-1:0] id_reg,
  input  logic             id_use,
  output logic             match
);

  // $0 is hardwired to zero, so a write to it never creates a dependence.
  assign match = stage.valid & stage.regwrite & (stage.dst != '0) &
                 (stage.dst == id_reg) & id_use;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall controller for the 5-stage pipeline.
// Tracks EX/MEM/WB destination metadata in a shadow pipeline.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned REG_W = fwd_pkg::REG_W,
  parameter int unsigned SEL_W = fwd_pkg::SEL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  output logic [SEL_W-1:0] fwd_a_sel,
  output logic [SEL_W-1:0] fwd_b_sel,
  output logic             stall,
  output logic             ex_bubble
);

  stage_t ex_q, mem_q, wb_q;
  stage_t ex_d;
  state_e state_q, state_d;
  logic [SEL_W-1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  logic ex_rs_m, ex_rt_m, mem_rs_m, mem_rt_m;
  logic load_use, advance;

  fwd_match u_ex_rs (
    .stage  (ex_q),
    .id_reg (id_rs),
    .id_use (id_use_rs),
    .match  (ex_rs_m)
  );

  fwd_match u_ex_rt (
    .stage  (ex_q),
    .id_reg (id_rt),
    .id_use (id_use_rt),
    .match  (ex_rt_m)
  );

  fwd_match u_mem_rs (
    .stage  (mem_q),
    .id_reg (id_rs),
    .id_use (id_use_rs),
    .match  (mem_rs_m)
  );

  fwd_match u_mem_rt (
    .stage  (mem_q),
    .id_reg (id_rt),
    .id_use (id_use_rt),
    .match  (mem_rt_m)
  );

  assign load_use = (ex_rs_m | ex_rt_m) & ex_q.memread;

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    ex_bubble = 1'b0;
    ex_d      = '0;
    fwd_a_d   = SEL_REGF;
    fwd_b_d   = SEL_REGF;

    // Flush dominates: the ID instruction dies, so there is nothing to stall for.
    if (flush) begin
      ex_bubble = 1'b1;
      state_d   = StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          if (load_use) begin
            stall     = 1'b1;
            ex_bubble = 1'b1;
            state_d   = StLuStall;
          end
        end
        StLuStall: state_d = StRun;
        default:   state_d = StRun;
      endcase
    end

    advance = id_valid & ~stall & ~flush;

    if (advance) begin
      ex_d.valid    = 1'b1;
      ex_d.dst      = id_dst;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
      // The nearer producer holds the newer value, so EX beats MEM.
      fwd_a_d = ex_rs_m ? SEL_MEM : (mem_rs_m ? SEL_WB : SEL_REGF);
      fwd_b_d = ex_rt_m ? SEL_MEM : (mem_rt_m ? SEL_WB : SEL_REGF);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= StRun;
      fwd_a_q <= SEL_REGF;
      fwd_b_q <= SEL_REGF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      state_q <= state_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench: directed instruction sequences with a queue of expected
// EX-cycle selects, pushed in the ID cycle and compared one cycle later.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       id_use_rs, id_use_rt, id_regwrite, id_memread, flush;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall, ex_bubble;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
  } sel_t;

  sel_t exp_q[$];

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_dst      (id_dst),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .stall       (stall),
    .ex_bubble   (ex_bubble)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare last cycle's selects, drive ID, check stall/bubble,
  // push the selects expected in the next cycle.
  task automatic cyc(input string tag, input logic rst, input logic v,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic ur, input logic ut, input logic [4:0] dst,
                     input logic rw, input logic mr, input logic fl,
                     input logic es, input logic eb,
                     input logic [1:0] ea, input logic [1:0] ebs);
    sel_t s;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      check({tag, ".prev_sel_a"}, int'(fwd_a_sel), int'(s.a));
      check({tag, ".prev_sel_b"}, int'(fwd_b_sel), int'(s.b));
    end
    reset = rst; id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = ur; id_use_rt = ut;
    id_dst = dst; id_regwrite = rw; id_memread = mr; flush = fl;
    #1;
    if (rst) begin
      exp_q.delete();
      s = '{a: 2'b00, b: 2'b00};
    end else begin
      check({tag, ".stall"}, int'(stall), int'(es));
      check({tag, ".ex_bubble"}, int'(ex_bubble), int'(eb));
      s = '{a: ea, b: ebs};
    end
    exp_q.push_back(s);
  endtask

  task automatic nop(input string tag);
    cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) nop("drain");
  endtask

  initial begin
    reset = 1'b1; id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_dst = 0; id_regwrite = 0; id_memread = 0; flush = 0;

    // Reset with arbitrary inputs
    for (int i = 0; i < 2; i++)
      cyc("reset", 1, 1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
          1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          0, 0, 2'b00, 2'b00);
    nop("post_reset");
    check("reset.stall", int'(stall), 0);
    check("reset.bubble", int'(ex_bubble), 0);
    // Empty shadows: a consumer of $1 needs no forwarding
    cyc("empty", 0, 1, 1, 1, 1, 1, 2, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    drain();

    // add $3,$1,$2 ; sub $4,$3,$5
    cyc("exmem.add", 0, 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    cyc("exmem.sub", 0, 1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 0, 2'b10, 2'b00);
    drain();

    // lw $8,0($9) ; add $10,$8,$8
    cyc("lu.lw", 0, 1, 9, 8, 1, 0, 8, 1, 1, 0, 0, 0, 2'b00, 2'b00);
    cyc("lu.stall", 0, 1, 8, 8, 1, 1, 10, 1, 0, 0, 1, 1, 2'b00, 2'b00);
    cyc("lu.retry", 0, 1, 8, 8, 1, 1, 10, 1, 0, 0, 0, 0, 2'b01, 2'b01);
    drain();

    // add $3 ; add $3 ; or $6,$3,$3
    cyc("prio.add1", 0, 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    cyc("prio.add2", 0, 1, 4, 5, 1, 1, 3, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    cyc("prio.or", 0, 1, 3, 3, 1, 1, 6, 1, 0, 0, 0, 0, 2'b10, 2'b10);
    drain();

    // Distance 2 and 3 on operand A
    cyc("d2.add", 0, 1, 1, 2, 1, 1, 7, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    cyc("d2.mid", 0, 1, 1, 2, 1, 1, 9, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    cyc("d2.use", 0, 1, 7, 1, 1, 1, 11, 1, 0, 0, 0, 0, 2'b01, 2'b00);
    drain();
    cyc("d3.add", 0, 1, 1, 2, 1, 1, 7, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    nop("d3.gap1");
    nop("d3.gap2");
    cyc("d3.use", 0, 1, 2, 7, 1, 1, 11, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    drain();

    // Unused operand never forwards; rt-side EX match
    cyc("unused.add", 0, 1, 1, 2, 1, 1, 12, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    cyc("unused.use", 0, 1, 12, 12, 0, 1, 13, 1, 0, 0, 0, 0, 2'b00, 2'b10);
    drain();

    // Register $0: ALU producer and load producer
    cyc("zero.add", 0, 1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    cyc("zero.or", 0, 1, 0, 0, 1, 1, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    drain();
    cyc("zero.lw", 0, 1, 9, 0, 1, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00);
    cyc("zero.use", 0, 1, 0, 0, 1, 1, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    drain();

    // Flush during load-use, then a consumer finds the load in MEM
    cyc("fl.lw", 0, 1, 9, 8, 1, 0, 8, 1, 1, 0, 0, 0, 2'b00, 2'b00);
    cyc("fl.kill", 0, 1, 8, 8, 1, 1, 10, 1, 0, 1, 0, 1, 2'b00, 2'b00);
    cyc("fl.next", 0, 1, 8, 1, 1, 1, 11, 1, 0, 0, 0, 0, 2'b01, 2'b00);
    drain();
    // Plain flush with no hazard
    cyc("fl.plain", 0, 1, 1, 2, 1, 1, 3, 1, 0, 1, 0, 1, 2'b00, 2'b00);
    // Killed instruction must not have entered the shadow pipeline
    cyc("fl.ghost", 0, 1, 3, 3, 1, 1, 4, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    drain();

    // Reset mid-stall
    cyc("rs.lw", 0, 1, 9, 8, 1, 0, 8, 1, 1, 0, 0, 0, 2'b00, 2'b00);
    cyc("rs.stall", 0, 1, 8, 8, 1, 1, 10, 1, 0, 0, 1, 1, 2'b00, 2'b00);
    cyc("rs.reset", 1, 1, 8, 8, 1, 1, 10, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    cyc("rs.after", 0, 1, 8, 8, 1, 1, 10, 1, 0, 0, 0, 0, 2'b00, 2'b00);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Forwarding and load-use hazard controller for the 5-stage 32-bit pipeline. It tracks destination-register metadata for the EX, MEM and WB stages in its own shadow pipeline and produces the select lines for the EX-stage 32-bit operand multiplexers. It also produces the stall and bubble controls for the IF/ID and ID/EX registers. It sits beside the ID/EX pipeline register and drives the operand muxes in EX.

## Interface
Parameters:
- REG_W, 5, register-specifier width
- SEL_W, 2, forwarding-select width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all state
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_W  rs specifier of the ID instruction
- id_rt  in  REG_W  rt specifier of the ID instruction
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_dst  in  REG_W  destination specifier, already resolved rd/rt/31
- id_regwrite  in  1  ID instruction writes the register file
- id_memread  in  1  ID instruction is a load
- flush  in  1  branch/jump redirect; kills the ID instruction
- fwd_a_sel  out  SEL_W  EX operand-A mux select, registered
- fwd_b_sel  out  SEL_W  EX operand-B mux select, registered
- stall  out  1  hold PC and IF/ID; combinational
- ex_bubble  out  1  load NOP into ID/EX; combinational

## Operation
- **Select encoding:** SEL_REGF=2'b00 (register-file value), SEL_WB=2'b01 (MEM/WB result), SEL_MEM=2'b10 (EX/MEM ALU result). 2'b11 is never driven.
- **Shadow stages:** each of ex_, mem_ and wb_ holds {valid, dst, regwrite, memread}.
- **Every cycle:** wb<=mem and mem<=ex. ex<=ID fields if the ID instruction advances, otherwise ex<=bubble (all zero).
- **ID advances** when id_valid & ~stall & ~flush.
- **Hazard match:** stage S matches operand X when S.valid & S.regwrite & S.dst!=0 & S.dst==id_X & id_use_X.
- **Select computation:** fwd_X_sel is registered at the same edge that ID advances.
  - SEL_MEM if the current ex stage matches (that instruction is in MEM next cycle).
  - Otherwise SEL_WB if the current mem stage matches.
  - Otherwise SEL_REGF.
  - The nearer stage always wins.
- **WB-stage producer:** no forward is needed. The register file is write-before-read.
- **Load-use:** stall=ex_bubble=1 when the ex stage matches either used operand and ex.memread=1.
- **FSM:**
  - States RUN and LU_STALL; reset state RUN.
  - RUN→LU_STALL on load-use.
  - LU_STALL→RUN unconditionally. The load has moved to MEM, so the re-evaluated instruction gets SEL_WB.
  - stall is suppressed in LU_STALL, which bounds every load-use stall to exactly one cycle.
- **No advance** (stall, flush or ~id_valid): fwd_X_sel<=SEL_REGF.
- **flush:** dominates stall. stall=0 and ex_bubble=1 that cycle, FSM→RUN.
- **Register $0:** never matches and is never forwarded.

## Timing
- All outputs after reset: fwd_a_sel=fwd_b_sel=SEL_REGF, stall=0, ex_bubble=0, FSM=RUN, all shadow valid bits=0.
- Selects have 1-cycle latency: decided in the ID cycle, valid for the whole following EX cycle.
- stall and ex_bubble are combinational from ID inputs and ex-stage registers, valid within the same cycle.
- Back-to-back dependent ALU ops: SEL_MEM with zero stall.
- Dependence at distance 2: SEL_WB.
- Dependence at distance 3: SEL_REGF.
- Reset mid-stall: the next cycle is RUN with empty shadows, and stall=0.

## Structure
- Package fwd_pkg holds SEL_REGF, SEL_WB, SEL_MEM, the FSM state encoding, and a stage-metadata struct {valid, dst, regwrite, memread}.
- One sub-module, fwd_match: combinational stage-vs-operand comparator, instantiated four times (ex/mem × rs/rt).

## Test plan
- **Reset:** reset=1 for 2 cycles with arbitrary inputs → all outputs 0, shadows invalid.
- **EX/MEM forward:** `add $3,$1,$2` then `sub $4,$3,$5` → fwd_a_sel=2'b10 and fwd_b_sel=2'b00 in the sub's EX cycle, stall never 1.
- **Load-use:** `lw $8,0($9)` then `add $10,$8,$8` → stall=ex_bubble=1 for exactly one cycle. Then fwd_a_sel=fwd_b_sel=2'b01 in the add's EX cycle.
- **Priority:** `add $3`, `add $3`, then `or $6,$3,$3` → both selects 2'b10 (nearest producer).
- **Register $0:** producer writes $0, consumer reads $0 → selects 2'b00, no stall.
- **Flush during load-use:** load then dependent op with flush=1 in the same cycle → stall=0, ex_bubble=1, FSM stays RUN, next selects 2'b00.
